uart_tx_serializer: RTL and testbench



---
 rtl/uart_tx_serializer.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// Byte-wide UART transmitter. A byte is captured into a one-byte holding
// register by the load strobe and, once started by tx_enable, is sent on
// tx_out as an 8N1 frame: start bit (0), eight data bits LSB first, and a
// stop bit (1). Each bit lasts CLKS_PER_BIT system clocks. The holding
// register stays occupied until the stop bit has finished.
//
// Optional feature (compile-time macro UART_TX_PARITY_EN):
//   When defined, an even-parity bit (XOR of the eight data bits) is
//   inserted between the last data bit and the stop bit, giving 8E1.
//   When undefined, no parity state or parity logic exists.
//
// Upstream handshake (ld_tx_data / tx_empty):
//   A load is accepted on a rising clock edge where ld_tx_data=1 and
//   tx_empty=1; tx_empty reads 0 from the next cycle. A load presented while
//   tx_empty=0 is dropped and tx_overrun pulses for exactly the next cycle.
//   tx_enable only matters in IDLE with a byte held; it has no effect once a
//   frame is on the line.
//
// Parameters:
//   CLKS_PER_BIT  system clocks per UART bit (>= 2)
//   CNT_W         baud counter width (2**CNT_W >= CLKS_PER_BIT)
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   ld_tx_data   load strobe for tx_data
//   tx_data      byte to transmit
//   tx_enable    start request, sampled in IDLE only
//   tx_out       serial line, idles high (registered)
//   tx_empty     holding register free
//   tx_busy      a frame is on the line
//   tx_done      one-cycle pulse after the stop bit completes
//   tx_overrun   one-cycle pulse after a rejected load
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ld_tx_data,
   input  logic [7:0] tx_data,
   input  logic       tx_enable,
   output logic       tx_out,
   output logic       tx_empty,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_overrun
);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;
`endif

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       idx, idx_nxt;
   logic [7:0]       hold, hold_nxt;
   logic             tx_out_nxt;
   logic             empty_nxt;
   logic             done_nxt;
   logic             overrun_nxt;
   logic             bit_end;
   logic [2:0]       idx_inc;

   // State register. tx_out is registered so the line never glitches and
   // returns high the instant reset is asserted.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         hold       <= '0;
         tx_out     <= 1'b1;
         tx_empty   <= 1'b1;
         tx_done    <= 1'b0;
         tx_overrun <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         idx        <= idx_nxt;
         hold       <= hold_nxt;
         tx_out     <= tx_out_nxt;
         tx_empty   <= empty_nxt;
         tx_done    <= done_nxt;
         tx_overrun <= overrun_nxt;
      end
   end

   assign tx_busy = (state != IDLE);
   assign bit_end = (cnt == LAST_CNT);
   assign idx_inc = idx + 3'd1;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      idx_nxt     = idx;
      hold_nxt    = hold;
      tx_out_nxt  = tx_out;
      empty_nxt   = tx_empty;
      done_nxt    = 1'b0;
      overrun_nxt = 1'b0;

      // Load side. The register only accepts while empty, and it is only
      // emptied by stop-bit completion below, so a frame's byte can never
      // be overwritten while it is on the line.
      if (ld_tx_data) begin
         if (tx_empty) begin
            hold_nxt  = tx_data;
            empty_nxt = 1'b0;
         end else begin
            overrun_nxt = 1'b1;
         end
      end

      case (state)
         IDLE: begin
            cnt_nxt    = '0;
            idx_nxt    = '0;
            tx_out_nxt = 1'b1;
            if (tx_enable && !tx_empty) begin
               state_nxt  = START;
               tx_out_nxt = 1'b0;
            end
         end

         START: begin
            cnt_nxt = bit_end ? '0 : cnt + CNT_W'(1);
            if (bit_end) begin
               state_nxt  = DATA;
               idx_nxt    = '0;
               tx_out_nxt = hold[0];
            end
         end

         DATA: begin
            cnt_nxt = bit_end ? '0 : cnt + CNT_W'(1);
            if (bit_end) begin
               idx_nxt = idx_inc;
               if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_nxt  = PARITY;
                  tx_out_nxt = ^hold;
`else
                  state_nxt  = STOP;
                  tx_out_nxt = 1'b1;
`endif
               end else begin
                  tx_out_nxt = hold[idx_inc];
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         PARITY: begin
            cnt_nxt = bit_end ? '0 : cnt + CNT_W'(1);
            if (bit_end) begin
               state_nxt  = STOP;
               tx_out_nxt = 1'b1;
            end
         end
`endif

         STOP: begin
            cnt_nxt = bit_end ? '0 : cnt + CNT_W'(1);
            if (bit_end) begin
               state_nxt  = IDLE;
               tx_out_nxt = 1'b1;
               // Release the holding register; a load arriving on this
               // same edge already saw tx_empty=0 and was rejected above.
               empty_nxt  = 1'b1;
               done_nxt   = 1'b1;
            end
         end

         default: begin
            state_nxt  = IDLE;
            cnt_nxt    = '0;
            tx_out_nxt = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

   localparam int C = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   // ---------------- clock / reset ----------------
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       ld_tx_data = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_enable = 1'b0;
   logic       tx_out, tx_empty, tx_busy, tx_done, tx_overrun;

   always #5 clock = ~clock;

   uart_tx_serializer #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
      .clock      (clock),
      .reset      (reset),
      .ld_tx_data (ld_tx_data),
      .tx_data    (tx_data),
      .tx_enable  (tx_enable),
      .tx_out     (tx_out),
      .tx_empty   (tx_empty),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .tx_overrun (tx_overrun)
   );

   // ---------------- scoreboard state ----------------
   int         checks = 0;
   int         failures = 0;
   int         exp_ovr = 0;
   int         ovr_seen = 0;
   logic [7:0] exp_q[$];

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endfunction

   // Reference frame: start bit, data LSB first, optional even parity, stop.
   function automatic logic [NB-1:0] frame_bits(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
      return {1'b1, ^b, b, 1'b0};
`else
      return {1'b1, b, 1'b0};
`endif
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   always @(negedge clock) begin
      if (reset === 1'b0 && tx_overrun === 1'b1) ovr_seen++;
   end

   // ---------------- monitor ----------------
   initial begin : monitor
      logic [NB-1:0] fb;
      logic [7:0]    b;
      bit            aborted;
      bit            busy_ok;
      logic          seen;
      forever begin
         @(negedge clock);
         if (reset === 1'b0 && tx_out === 1'b0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", 32'd1, 32'd0);
               for (int w = 0; w < 20 * C && tx_busy === 1'b1; w++) @(negedge clock);
            end else begin
               b       = exp_q.pop_front();
               fb      = frame_bits(b);
               aborted = 1'b0;
               busy_ok = 1'b1;
               for (int k = 0; k < NB && !aborted; k++) begin
                  seen = fb[k];
                  for (int j = 0; j < C && !aborted; j++) begin
                     if (k != 0 || j != 0) @(negedge clock);
                     if (reset !== 1'b0) aborted = 1'b1;
                     else begin
                        if (tx_out !== fb[k]) seen = tx_out;
                        if (tx_busy !== 1'b1) busy_ok = 1'b0;
                     end
                  end
                  if (!aborted)
                     chk($sformatf("frame_%02h_bit%0d", b, k), 32'(seen), 32'(fb[k]));
               end
               if (!aborted) begin
                  chk($sformatf("frame_%02h_busy", b), 32'(busy_ok), 32'd1);
                  @(negedge clock);
                  if (reset === 1'b0) begin
                     chk($sformatf("frame_%02h_done", b), 32'(tx_done), 32'd1);
                     chk($sformatf("frame_%02h_empty", b), 32'(tx_empty), 32'd1);
                     chk($sformatf("frame_%02h_idle_out", b), 32'(tx_out), 32'd1);
                     chk($sformatf("frame_%02h_idle_busy", b), 32'(tx_busy), 32'd0);
                     @(negedge clock);
                     if (reset === 1'b0)
                        chk($sformatf("frame_%02h_done_width", b), 32'(tx_done), 32'd0);
                  end
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(negedge clock);
   endtask

   task automatic do_load(input logic [7:0] b, input bit accept);
      ld_tx_data = 1'b1;
      tx_data    = b;
      cyc();
      ld_tx_data = 1'b0;
      tx_data    = 8'($urandom);
      chk("load_overrun", 32'(tx_overrun), accept ? 32'd0 : 32'd1);
      chk("load_empty", 32'(tx_empty), 32'd0);
      if (!accept) exp_ovr++;
   endtask

   task automatic start(input logic [7:0] b, input int hold);
      tx_enable = 1'b1;
      exp_q.push_back(b);
      cyc();
      chk("start_low", 32'(tx_out), 32'd0);
      chk("start_busy", 32'(tx_busy), 32'd1);
      repeat (hold - 1) cyc();
      tx_enable = 1'b0;
   endtask

   task automatic reject_hold(input int n);
      ld_tx_data = 1'b1;
      repeat (n) begin
         tx_data = 8'($urandom);
         cyc();
         chk("held_load_overrun", 32'(tx_overrun), 32'd1);
         exp_ovr++;
      end
      ld_tx_data = 1'b0;
      cyc();
      chk("overrun_one_cycle", 32'(tx_overrun), 32'd0);
      chk("empty_during_frame", 32'(tx_empty), 32'd0);
   endtask

   task automatic wait_done();
      int n = 0;
      while (tx_done !== 1'b1 && n < 300) begin
         cyc();
         n++;
      end
      chk("wait_done_timeout", 32'(n >= 300), 32'd0);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(tx_empty === 1'b1 && tx_busy === 1'b0) && n < 300) begin
         cyc();
         n++;
      end
      chk("wait_idle_timeout", 32'(n >= 300), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin : driver
      logic [7:0] b;
      bit         out_ok, busy_ok, done_ok;

      // Reset values
      repeat (2) cyc();
      chk("rst_tx_out", 32'(tx_out), 32'd1);
      chk("rst_tx_empty", 32'(tx_empty), 32'd1);
      chk("rst_tx_busy", 32'(tx_busy), 32'd0);
      chk("rst_tx_done", 32'(tx_done), 32'd0);
      chk("rst_tx_overrun", 32'(tx_overrun), 32'd0);
      reset = 1'b0;
      repeat (2) cyc();

      // Plain frame
      do_load(8'hA5, 1'b1);
      start(8'hA5, 1);
      wait_done();

      // Back-to-back: load and enable in the first idle cycle after stop
      tx_enable = 1'b1;
      exp_q.push_back(8'h2C);
      do_load(8'h2C, 1'b1);
      chk("b2b_gap_out", 32'(tx_out), 32'd1);
      chk("b2b_gap_busy", 32'(tx_busy), 32'd0);
      cyc();
      tx_enable = 1'b0;
      chk("b2b_start_low", 32'(tx_out), 32'd0);
      repeat (2 * C) cyc();
      do_load(8'h55, 1'b0);
      cyc();
      chk("overrun_pulse_end", 32'(tx_overrun), 32'd0);
      chk("empty_held", 32'(tx_empty), 32'd0);
      wait_done();

      // Reset during bit 3 of 0xFF
      cyc();
      do_load(8'hFF, 1'b1);
      start(8'hFF, 1);
      repeat (4 * C + 1) cyc();
      @(posedge clock);
      #1 reset = 1'b1;
      #2;
      chk("async_rst_out", 32'(tx_out), 32'd1);
      chk("async_rst_empty", 32'(tx_empty), 32'd1);
      chk("async_rst_busy", 32'(tx_busy), 32'd0);
      repeat (2) cyc();
      reset = 1'b0;
      cyc();
      do_load(8'h00, 1'b1);
      start(8'h00, 1);
      wait_done();

      // Enable with nothing loaded
      repeat (2) cyc();
      tx_enable = 1'b1;
      out_ok = 1'b1; busy_ok = 1'b1; done_ok = 1'b1;
      repeat (20) begin
         cyc();
         if (tx_out !== 1'b1) out_ok = 1'b0;
         if (tx_busy !== 1'b0) busy_ok = 1'b0;
         if (tx_done !== 1'b0) done_ok = 1'b0;
      end
      tx_enable = 1'b0;
      chk("empty_enable_out", 32'(out_ok), 32'd1);
      chk("empty_enable_busy", 32'(busy_ok), 32'd1);
      chk("empty_enable_done", 32'(done_ok), 32'd1);

      // Enable held 10 cycles, held load rejected, load on final stop cycle
      do_load(8'h2C, 1'b1);
      start(8'h2C, 10);
      reject_hold(3);
      repeat (NB * C - 1 - 13) cyc();
      ld_tx_data = 1'b1;
      tx_data    = 8'h99;
      cyc();
      ld_tx_data = 1'b0;
      exp_ovr++;
      chk("stop_edge_load_overrun", 32'(tx_overrun), 32'd1);
      chk("stop_edge_load_done", 32'(tx_done), 32'd1);
      chk("stop_edge_load_empty", 32'(tx_empty), 32'd1);

      // Randomised frames
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom);
         repeat ($urandom_range(0, 3)) cyc();
         do_load(b, 1'b1);
         start(b, $urandom_range(1, 12));
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 20)) cyc();
            reject_hold($urandom_range(1, 3));
         end
         wait_done();
      end

      wait_idle();
      repeat (3) cyc();
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      chk("overrun_count", 32'(ovr_seen), 32'(exp_ovr));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
